// File: rtl/reorder_collect_if.sv
// Handshake bundle for reorder_collect.
//   din_*    : write beats (reordered position, sample, granule/channel tag, last marker)
//   din_ready: beat accepted when din_v && din_ready
//   dout_*   : sequential sample stream with index, tag and last marker
//   dout_ready: sample transfers when dout_v && dout_ready
//   err_pos  : one-cycle pulse after an accepted beat with an out-of-range position
// The master side is the producer/consumer around the block; the slave side is the block.
interface reorder_collect_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  din_v;
  logic [9:0]            din_pos;
  logic [DATA_WIDTH-1:0] din_data;
  logic [1:0]            din_grch;
  logic                  din_last;
  logic                  din_ready;
  logic                  dout_v;
  logic [DATA_WIDTH-1:0] dout_data;
  logic [9:0]            dout_idx;
  logic [1:0]            dout_grch;
  logic                  dout_last;
  logic                  dout_ready;
  logic                  err_pos;

  modport master (
    output din_v, din_pos, din_data, din_grch, din_last, dout_ready,
    input  din_ready, dout_v, dout_data, dout_idx, dout_grch, dout_last, err_pos
  );

  modport slave (
    input  din_v, din_pos, din_data, din_grch, din_last, dout_ready,
    output din_ready, dout_v, dout_data, dout_idx, dout_grch, dout_last, err_pos
  );
endinterface

// File: rtl/reorder_collect.sv
// reorder_collect: double-buffered sample reorder stage.
// Beats arrive in arbitrary (reordered) position order and are written into the current
// write bank; din_last closes the bank (FULL) and swaps to the other bank. Full banks are
// streamed out in arrival order as indices 0..NSAMP-1. Positions never written in a granule
// read as zero, so a producer only has to send the non-zero region.
// Ports:
//   clk   : clock, all state on its rising edge
//   rst_n : synchronous active-low reset, discards all stored data
//   bus   : reorder_collect_if slave modport (write beats in, sample stream out, err_pos)
module reorder_collect #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NSAMP      = 576
) (
  input  logic             clk,
  input  logic             rst_n,
  reorder_collect_if.slave bus
);

  localparam logic [9:0] LastIdx = 10'(NSAMP - 1);

  typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull} bank_st_e;
  typedef enum logic {StIdle, StStream} rd_st_e;

  // Per-bank state, written-flag vectors and granule tags
  bank_st_e              bank_st_q [2];
  bank_st_e              bank_st_d [2];
  logic [NSAMP-1:0]      wflag_q   [2];
  logic [NSAMP-1:0]      wflag_d   [2];
  logic [1:0]            tag_q     [2];
  logic [1:0]            tag_d     [2];
  logic [DATA_WIDTH-1:0] mem_q     [2][NSAMP];

  logic   wr_bank_q, wr_bank_d;
  logic   rd_bank_q, rd_bank_d;
  rd_st_e rd_st_q, rd_st_d;

  // Registered output stage
  logic                  dout_v_q, dout_v_d;
  logic [DATA_WIDTH-1:0] dout_data_q, dout_data_d;
  logic [9:0]            dout_idx_q, dout_idx_d;
  logic [1:0]            dout_grch_q, dout_grch_d;
  logic                  dout_last_q, dout_last_d;
  logic                  err_q, err_d;

  logic       din_ready;
  logic       accept;
  logic       pos_ok;
  logic       do_write;
  logic       load;
  logic [9:0] load_idx;

  assign pos_ok    = (bus.din_pos <= LastIdx);
  // The write bank can never be the streaming bank: a bank only streams once FULL.
  assign din_ready = rst_n && (bank_st_q[wr_bank_q] != BkFull);
  assign accept    = bus.din_v && din_ready;
  assign do_write  = accept && pos_ok;

  // Sample storage; no reset needed since the written flags mask stale contents.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_bank_q][bus.din_pos] <= bus.din_data;
    end
  end

  always_comb begin
    bank_st_d   = bank_st_q;
    wflag_d     = wflag_q;
    tag_d       = tag_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    rd_st_d     = rd_st_q;
    dout_v_d    = dout_v_q;
    dout_data_d = dout_data_q;
    dout_idx_d  = dout_idx_q;
    dout_grch_d = dout_grch_q;
    dout_last_d = dout_last_q;
    err_d       = accept && !pos_ok;
    load        = 1'b0;
    load_idx    = '0;

    // Write side
    if (accept) begin
      if (pos_ok) begin
        wflag_d[wr_bank_q][bus.din_pos] = 1'b1;
        bank_st_d[wr_bank_q]            = BkFilling;
      end
      if (bus.din_last) begin
        bank_st_d[wr_bank_q] = BkFull;
        tag_d[wr_bank_q]     = bus.din_grch;
        wr_bank_d            = ~wr_bank_q;
      end
    end

    // Read side; touches only the read bank, so it composes with a same-cycle write-side
    // update of the other bank.
    unique case (rd_st_q)
      StIdle: begin
        if (bank_st_q[rd_bank_q] == BkFull) begin
          rd_st_d  = StStream;
          load     = 1'b1;
          load_idx = '0;
        end
      end
      StStream: begin
        if (dout_v_q && bus.dout_ready) begin
          if (dout_last_q) begin
            rd_st_d              = StIdle;
            bank_st_d[rd_bank_q] = BkEmpty;
            wflag_d[rd_bank_q]   = '0;
            rd_bank_d            = ~rd_bank_q;
            dout_v_d             = 1'b0;
            dout_data_d          = '0;
            dout_idx_d           = '0;
            dout_grch_d          = '0;
            dout_last_d          = 1'b0;
          end else begin
            load     = 1'b1;
            load_idx = dout_idx_q + 10'd1;
          end
        end
      end
      default: rd_st_d = StIdle;
    endcase

    if (load) begin
      dout_v_d    = 1'b1;
      dout_idx_d  = load_idx;
      dout_data_d = wflag_q[rd_bank_q][load_idx] ? mem_q[rd_bank_q][load_idx] : '0;
      dout_grch_d = tag_q[rd_bank_q];
      dout_last_d = (load_idx == LastIdx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_st_q   <= '{default: BkEmpty};
      wflag_q     <= '{default: '0};
      tag_q       <= '{default: '0};
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_st_q     <= StIdle;
      dout_v_q    <= 1'b0;
      dout_data_q <= '0;
      dout_idx_q  <= '0;
      dout_grch_q <= '0;
      dout_last_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bank_st_q   <= bank_st_d;
      wflag_q     <= wflag_d;
      tag_q       <= tag_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_st_q     <= rd_st_d;
      dout_v_q    <= dout_v_d;
      dout_data_q <= dout_data_d;
      dout_idx_q  <= dout_idx_d;
      dout_grch_q <= dout_grch_d;
      dout_last_q <= dout_last_d;
      err_q       <= err_d;
    end
  end

  assign bus.din_ready = din_ready;
  assign bus.dout_v    = dout_v_q;
  assign bus.dout_data = dout_data_q;
  assign bus.dout_idx  = dout_idx_q;
  assign bus.dout_grch = dout_grch_q;
  assign bus.dout_last = dout_last_q;
  assign bus.err_pos   = err_q;

endmodule

// File: tb/tb_reorder_collect.sv
// Self-checking bench for reorder_collect (DATA_WIDTH=32, NSAMP=576).
// A reference model keeps the expected output stream as a flat queue of samples plus a
// queue of granule tags; every transfer, stall, err_pos pulse and din_ready is compared.
module tb_reorder_collect;

  localparam int N = 576;

  logic clk;
  logic rst_n;

  reorder_collect_if #(.DATA_WIDTH(32)) bus ();

  reorder_collect #(.DATA_WIDTH(32), .NSAMP(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] fill_buf [N];
  logic [31:0] exp_data [$];
  logic [1:0]  exp_tag  [$];
  int          out_cnt = 0;

  // Bench bookkeeping
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready
  logic        last_acc = 1'b0;
  int          err_seen = 0;
  logic [31:0] cap_data [N];
  logic        gap_on = 1'b0;
  int          gap = 0;
  int          gap_min = 0;

  typedef struct {
    int          pos;
    logic [31:0] data;
    logic [1:0]  grch;
    int          exp_err;
    int          probe;
    logic [31:0] exp_probe;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) fill_buf[i] = '0;
    exp_data.delete();
    exp_tag.delete();
    out_cnt = 0;
    gap_on  = 1'b0;
  endtask

  // One clock: inputs are already set; sample pre-edge, update model, check post-edge.
  task automatic cycle();
    logic        rst_on, acc, xfer, stall, exp_err, popped, pushed_new;
    logic [31:0] s_data;
    logic [9:0]  s_idx;
    logic [1:0]  s_grch;
    logic        s_last;
    case (rdy_mode)
      0:       bus.dout_ready = 1'b1;
      1:       bus.dout_ready = 1'($urandom_range(0, 1));
      default: bus.dout_ready = 1'b0;
    endcase
    #1;
    rst_on = rst_n;
    chk("din_ready", 32'(bus.din_ready), 32'(rst_on && (exp_tag.size() < 2)));
    acc     = rst_on && bus.din_v && bus.din_ready;
    xfer    = rst_on && bus.dout_v && bus.dout_ready;
    stall   = rst_on && bus.dout_v && !bus.dout_ready;
    s_data  = bus.dout_data;
    s_idx   = bus.dout_idx;
    s_grch  = bus.dout_grch;
    s_last  = bus.dout_last;
    exp_err = acc && (int'(bus.din_pos) >= N);
    last_acc   = acc;
    popped     = 1'b0;
    pushed_new = 1'b0;
    if (!rst_on) begin
      model_reset();
    end else begin
      if (xfer) begin
        if (exp_tag.size() == 0) begin
          chk("xfer_granule_avail", 32'(exp_tag.size()), 32'd1);
        end else begin
          chk("dout_idx", 32'(s_idx), 32'(out_cnt));
          chk("dout_data", s_data, exp_data[0]);
          chk("dout_grch", 32'(s_grch), 32'(exp_tag[0]));
          chk("dout_last", 32'(s_last), 32'(out_cnt == N - 1));
          if (int'(s_idx) < N) cap_data[s_idx] = s_data;
          void'(exp_data.pop_front());
          out_cnt++;
          if (out_cnt == N) begin
            out_cnt = 0;
            void'(exp_tag.pop_front());
            popped = 1'b1;
          end
        end
      end
      if (acc) begin
        if (int'(bus.din_pos) < N) fill_buf[bus.din_pos] = bus.din_data;
        if (bus.din_last) begin
          pushed_new = (exp_tag.size() == 0);
          for (int i = 0; i < N; i++) begin
            exp_data.push_back(fill_buf[i]);
            fill_buf[i] = '0;
          end
          exp_tag.push_back(bus.din_grch);
        end
      end
      if ((popped || pushed_new) && exp_tag.size() > 0) begin
        gap_on  = 1'b1;
        gap     = 0;
        gap_min = pushed_new ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    chk("err_pos", 32'(bus.err_pos), 32'(exp_err));
    if (bus.err_pos) err_seen++;
    if (!rst_on) begin
      chk("rst_dout_v", 32'(bus.dout_v), 32'd0);
      chk("rst_dout_data", bus.dout_data, 32'd0);
      chk("rst_dout_idx", 32'(bus.dout_idx), 32'd0);
      chk("rst_dout_grch", 32'(bus.dout_grch), 32'd0);
      chk("rst_dout_last", 32'(bus.dout_last), 32'd0);
    end
    if (stall) begin
      chk("hold_v", 32'(bus.dout_v), 32'd1);
      chk("hold_data", bus.dout_data, s_data);
      chk("hold_idx", 32'(bus.dout_idx), 32'(s_idx));
      chk("hold_grch", 32'(bus.dout_grch), 32'(s_grch));
      chk("hold_last", 32'(bus.dout_last), 32'(s_last));
    end
    if (bus.dout_v && exp_tag.size() == 0) begin
      chk("dout_v_without_full_bank", 32'(exp_tag.size()), 32'd1);
    end
    if (gap_on) begin
      if (bus.dout_v) begin
        chk("stream_start_gap_ok", 32'(gap >= gap_min && gap <= 2), 32'd1);
        gap_on = 1'b0;
      end else begin
        gap++;
        if (gap > 2) begin
          chk("stream_start_gap", 32'(gap), 32'd2);
          gap_on = 1'b0;
        end
      end
    end
  endtask

  task automatic send_beat(input int pos, input logic [31:0] data, input logic [1:0] grch,
                           input logic last);
    int   n;
    logic done;
    bus.din_v    = 1'b1;
    bus.din_pos  = 10'(pos);
    bus.din_data = data;
    bus.din_grch = grch;
    bus.din_last = last;
    n    = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      cycle();
      done = last_acc;
      n++;
    end
    if (!done) chk("beat_accept_timeout", 32'(done), 32'd1);
    bus.din_v    = 1'b0;
    bus.din_last = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_tag.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_complete", 32'(exp_tag.size()), 32'd0);
  endtask

  task automatic full_granule(input logic [1:0] grch);
    for (int p = N - 1; p >= 0; p--) send_beat(p, 32'(p + 100), grch, p == 0);
  endtask

  task automatic rand_granule(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) cycle();
      send_beat($urandom_range(0, 639), $urandom, 2'($urandom_range(0, 3)), b == nbeats - 1);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{3,    32'h0000_ABCD, 2'd1, 0, 3,   32'h0000_ABCD};
    vecs[1] = '{600,  32'h0000_1234, 2'd3, 1, 0,   32'h0};
    vecs[2] = '{0,    32'h0000_0005, 2'd0, 0, 0,   32'h5};
    vecs[3] = '{575,  32'hFFFF_FFFF, 2'd2, 0, 575, 32'hFFFF_FFFF};
    vecs[4] = '{576,  32'h0000_0007, 2'd1, 1, 575, 32'h0};
    vecs[5] = '{1023, 32'h0000_0009, 2'd0, 1, 3,   32'h0};

    rst_n        = 1'b0;
    bus.din_v    = 1'b0;
    bus.din_pos  = '0;
    bus.din_data = '0;
    bus.din_grch = '0;
    bus.din_last = 1'b0;
    bus.dout_ready = 1'b1;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Full reversed granule, always ready
    rdy_mode = 0;
    full_granule(2'd2);
    drain(2000);

    // Same granule with random backpressure
    rdy_mode = 1;
    full_granule(2'd2);
    drain(4000);

    // Single-beat granules from the vector table
    rdy_mode = 0;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) cap_data[i] = 32'hDEAD_BEEF;
      err_seen = 0;
      send_beat(vecs[v].pos, vecs[v].data, vecs[v].grch, 1'b1);
      drain(2000);
      chk("vec_err_pulses", 32'(err_seen), 32'(vecs[v].exp_err));
      chk("vec_probe", cap_data[vecs[v].probe], vecs[v].exp_probe);
      chk("vec_other_zero", cap_data[(vecs[v].probe + 1) % N], 32'h0);
    end

    // Both banks full with a stalled consumer; third granule waits for a free bank
    rdy_mode = 2;
    rand_granule(8);
    rand_granule(8);
    bus.din_v    = 1'b1;
    bus.din_pos  = 10'd7;
    bus.din_data = 32'h5555_0007;
    bus.din_grch = 2'd3;
    bus.din_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("stall_no_accept", 32'(last_acc), 32'd0);
    end
    rdy_mode = 0;
    send_beat(7, 32'h5555_0007, 2'd3, 1'b0);
    send_beat(500, 32'h5555_01F4, 2'd3, 1'b0);
    send_beat(7, 32'h6666_0007, 2'd3, 1'b1);
    drain(4000);

    // Reset in the middle of a stream
    rdy_mode = 0;
    full_granule(2'd1);
    n = 0;
    while (!(bus.dout_v && bus.dout_idx == 10'd200) && n < 2000) begin
      cycle();
      n++;
    end
    chk("reach_idx_200", 32'(bus.dout_idx), 32'd200);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_dout_v", 32'(bus.dout_v), 32'd0);
    rst_n = 1'b1;
    cycle();
    send_beat(10, 32'h0BAD_F00D, 2'd2, 1'b1);
    drain(2000);

    // Randomized granules with random backpressure
    rdy_mode = 1;
    for (int g = 0; g < 4; g++) rand_granule($urandom_range(1, 40));
    drain(8000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
